// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared register offsets, status bit indices and capture FSM states
package pwm_capture_pkg;

    // Register offsets, decoded from PADDR[12:0]
    localparam logic [12:0] ADDR_XW   = 13'h100;
    localparam logic [12:0] ADDR_YW   = 13'h104;
    localparam logic [12:0] ADDR_XP   = 13'h108;
    localparam logic [12:0] ADDR_YP   = 13'h10C;
    localparam logic [12:0] ADDR_STAT = 13'h110;

    // Bit positions inside the status register
    localparam int STAT_X_VALID = 0;
    localparam int STAT_Y_VALID = 1;
    localparam int STAT_X_NEW   = 2;
    localparam int STAT_Y_NEW   = 3;
    localparam int STAT_X_LOST  = 4;
    localparam int STAT_Y_LOST  = 5;
    localparam int STAT_W       = 6;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_t;

endpackage

// File: rtl/pwm_capture_channel.sv
// rtl/pwm_capture_channel.sv - single-channel PWM width/period capture engine
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_pwm            asynchronous PWM input
//   i_clr_new        clear the new-measurement flag (commit in the same cycle wins)
//   i_clr_lost       clear the lost flag (timeout in the same cycle wins)
//   o_width          latched high-pulse width in clock cycles
//   o_period         latched rise-to-rise period in clock cycles
//   o_valid          a measurement is held
//   o_new            a measurement was committed since the last clear
//   o_lost           the channel timed out since the last clear
module pwm_capture_channel
    import pwm_capture_pkg::*;
#(
    parameter int TIMEOUT = 5000000,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pwm,
    input  logic             i_clr_new,
    input  logic             i_clr_lost,
    output logic [CNT_W-1:0] o_width,
    output logic [CNT_W-1:0] o_period,
    output logic             o_valid,
    output logic             o_new,
    output logic             o_lost
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    logic             r_s1, r_s2, r_s3;
    logic [2:0]       r_arm;
    cap_state_t       r_state;
    logic [CNT_W-1:0] r_cnt, r_pend, r_width, r_period;
    logic             r_valid, r_new, r_lost;

    cap_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt, w_pend_nxt, w_width_nxt, w_period_nxt;
    logic             w_valid_nxt, w_new_nxt, w_lost_nxt;
    logic             w_commit, w_tmo;
    logic             w_rise, w_fall;

    // The synchronizer flops restart from 0, so an input already high at
    // reset release would look like a rise. r_arm fills with ones as real
    // samples reach r_s3; rises are only trusted once the pipeline is full,
    // which keeps a pulse that straddles reset from being measured.
    assign w_rise = r_s2 & ~r_s3 & r_arm[2];
    assign w_fall = ~r_s2 & r_s3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s3     <= 1'b0;
            r_arm    <= '0;
            r_state  <= SYNC;
            r_cnt    <= '0;
            r_pend   <= '0;
            r_width  <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_new    <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_s1     <= i_pwm;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_arm    <= {r_arm[1:0], 1'b1};
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pend   <= w_pend_nxt;
            r_width  <= w_width_nxt;
            r_period <= w_period_nxt;
            r_valid  <= w_valid_nxt;
            r_new    <= w_new_nxt;
            r_lost   <= w_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pend_nxt   = r_pend;
        w_width_nxt  = r_width;
        w_period_nxt = r_period;
        w_valid_nxt  = r_valid;
        w_commit     = 1'b0;
        w_tmo        = 1'b0;

        case (r_state)
            SYNC: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            HIGH: begin
                if (r_cnt == TMO) begin
                    w_tmo = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_fall) begin
                        w_state_nxt = LOW;
                        w_pend_nxt  = r_cnt;
                    end
                end
            end
            LOW: begin
                // Timeout is checked first so a rise landing on the timeout
                // cycle is dropped; the following rise restarts capture.
                if (r_cnt == TMO) begin
                    w_tmo = 1'b1;
                end else if (w_rise) begin
                    w_state_nxt  = HIGH;
                    w_cnt_nxt    = CNT_W'(1);
                    w_commit     = 1'b1;
                    w_width_nxt  = r_pend;
                    w_period_nxt = r_cnt;
                    w_valid_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = SYNC;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_tmo) begin
            w_state_nxt  = SYNC;
            w_cnt_nxt    = '0;
            w_width_nxt  = '0;
            w_period_nxt = '0;
            w_valid_nxt  = 1'b0;
        end

        // Set beats clear on both sticky flags
        w_new_nxt  = w_commit | (r_new & ~i_clr_new);
        w_lost_nxt = w_tmo | (r_lost & ~i_clr_lost);
    end

    assign o_width  = r_width;
    assign o_period = r_period;
    assign o_valid  = r_valid;
    assign o_new    = r_new;
    assign o_lost   = r_lost;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - APB3 two-channel servo PWM width/period capture
//
// Ports:
//   PCLK, PRESET        clock, synchronous active-high reset
//   PSEL, PENABLE       APB select / access phase
//   PWRITE              1 = write, 0 = read
//   PADDR, PWDATA       address (bits 12:0 decoded) and write data
//   PRDATA              read data, combinational from PADDR while PSEL && !PWRITE
//   PREADY, PSLVERR     constant 1 / constant 0
//   x_pwm_in, y_pwm_in  asynchronous PWM inputs
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int TIMEOUT = 5000000,
    parameter int CNT_W   = 32
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        x_pwm_in,
    input  logic        y_pwm_in
);

    logic [12:0]       w_addr;
    logic              w_rd_en, w_rd_acc, w_wr_acc;
    logic              w_clr_new_x, w_clr_new_y, w_clr_lost_x, w_clr_lost_y;
    logic [CNT_W-1:0]  w_x_width, w_x_period, w_y_width, w_y_period;
    logic              w_x_valid, w_x_new, w_x_lost;
    logic              w_y_valid, w_y_new, w_y_lost;
    logic [STAT_W-1:0] w_status;
    logic              w_unused;

    assign w_addr   = PADDR[12:0];
    assign w_rd_en  = PSEL & ~PWRITE;
    assign w_rd_acc = w_rd_en & PENABLE;
    assign w_wr_acc = PSEL & PWRITE & PENABLE;

    // Reading a width register acknowledges that channel's new measurement
    assign w_clr_new_x  = w_rd_acc && (w_addr == ADDR_XW);
    assign w_clr_new_y  = w_rd_acc && (w_addr == ADDR_YW);
    assign w_clr_lost_x = w_wr_acc && (w_addr == ADDR_STAT) && PWDATA[STAT_X_LOST];
    assign w_clr_lost_y = w_wr_acc && (w_addr == ADDR_STAT) && PWDATA[STAT_Y_LOST];

    assign w_unused = ^{PADDR[31:13], PWDATA[31:6], PWDATA[3:0]};

    pwm_capture_channel #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_ch_x (
        .i_clk      (PCLK),
        .i_rst      (PRESET),
        .i_pwm      (x_pwm_in),
        .i_clr_new  (w_clr_new_x),
        .i_clr_lost (w_clr_lost_x),
        .o_width    (w_x_width),
        .o_period   (w_x_period),
        .o_valid    (w_x_valid),
        .o_new      (w_x_new),
        .o_lost     (w_x_lost)
    );

    pwm_capture_channel #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_ch_y (
        .i_clk      (PCLK),
        .i_rst      (PRESET),
        .i_pwm      (y_pwm_in),
        .i_clr_new  (w_clr_new_y),
        .i_clr_lost (w_clr_lost_y),
        .o_width    (w_y_width),
        .o_period   (w_y_period),
        .o_valid    (w_y_valid),
        .o_new      (w_y_new),
        .o_lost     (w_y_lost)
    );

    always_comb begin
        w_status               = '0;
        w_status[STAT_X_VALID] = w_x_valid;
        w_status[STAT_Y_VALID] = w_y_valid;
        w_status[STAT_X_NEW]   = w_x_new;
        w_status[STAT_Y_NEW]   = w_y_new;
        w_status[STAT_X_LOST]  = w_x_lost;
        w_status[STAT_Y_LOST]  = w_y_lost;
    end

    always_comb begin
        PRDATA = '0;
        if (w_rd_en) begin
            case (w_addr)
                ADDR_XW:   PRDATA = 32'(w_x_width);
                ADDR_YW:   PRDATA = 32'(w_y_width);
                ADDR_XP:   PRDATA = 32'(w_x_period);
                ADDR_YP:   PRDATA = 32'(w_y_period);
                ADDR_STAT: PRDATA = 32'(w_status);
                default:   PRDATA = '0;
            endcase
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;

    localparam int TMO = 1200;

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic        x_pwm_in = 1'b0;
    logic        y_pwm_in = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Pin drivers: manual level, or a free-running hi/lo pattern generator
    logic x_en = 1'b0, y_en = 1'b0, x_man = 1'b0, y_man = 1'b0;
    int   x_hi = 1, x_lo = 1, y_hi = 1, y_lo = 1;
    int   x_ph = 0, y_ph = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;
    vec_t tab[$];

    always #5 PCLK = ~PCLK;

    pwm_capture #(.TIMEOUT(TMO), .CNT_W(32)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .x_pwm_in (x_pwm_in),
        .y_pwm_in (y_pwm_in)
    );

    // Pins change 2 ns after each rising edge, after main-thread updates at 1 ns
    initial begin
        forever begin
            @(posedge PCLK);
            #2;
            if (x_en) begin
                x_pwm_in = (x_ph < x_hi);
                x_ph = (x_ph + 1 >= x_hi + x_lo) ? 0 : x_ph + 1;
            end else begin
                x_pwm_in = x_man;
                x_ph = 0;
            end
            if (y_en) begin
                y_pwm_in = (y_ph < y_hi);
                y_ph = (y_ph + 1 >= y_hi + y_lo) ? 0 : y_ph + 1;
            end else begin
                y_pwm_in = y_man;
                y_ph = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        tick(1);
        PENABLE = 1'b1;
        @(negedge PCLK);
        d = PRDATA;
        tick(1);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] v);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = v; PENABLE = 1'b0;
        tick(1);
        PENABLE = 1'b1;
        tick(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        check(name, d, exp);
    endtask

    task automatic apply_tab(input string label);
        logic [31:0] d;
        for (int i = 0; i < tab.size(); i++) begin
            apb_read(tab[i].addr, d);
            check($sformatf("%s[%0d]@%0h", label, i, tab[i].addr), d, tab[i].exp);
        end
        tab.delete();
    endtask

    task automatic fill_zero_tab();
        tab.push_back('{32'h100, 32'h0});
        tab.push_back('{32'h104, 32'h0});
        tab.push_back('{32'h108, 32'h0});
        tab.push_back('{32'h10C, 32'h0});
        tab.push_back('{32'h110, 32'h0});
        tab.push_back('{32'h1FC, 32'h0});
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        tick(3);
        PRESET = 1'b0;
    endtask

    // Reference: a steady hi/lo pattern always reports width=hi, period=hi+lo,
    // valid set and nothing lost; only bits 12:0 of the address are decoded.
    function automatic logic [31:0] model_reg(input logic [31:0] a);
        case (a[12:0])
            13'h100: return 32'(x_hi);
            13'h104: return 32'(y_hi);
            13'h108: return 32'(x_hi + x_lo);
            13'h10C: return 32'(y_hi + y_lo);
            13'h110: return 32'h03;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 32'h100;
            1: return 32'h104;
            2: return 32'h108;
            3: return 32'h10C;
            4: return 32'h110;
            5: return 32'h2104;
            6: return 32'h1FC;
            default: return 32'h1100;
        endcase
    endfunction

    task automatic random_reads(input string label, input int n);
        logic [31:0] a, d, m;
        for (int i = 0; i < n; i++) begin
            a = pick_addr();
            apb_read(a, d);
            m = (a[12:0] == 13'h110) ? 32'h33 : 32'hFFFF_FFFF;
            check($sformatf("%s rd%0d@%0h", label, i, a), d & m, model_reg(a));
        end
    endtask

    initial begin
        int d, px, py, w;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;

        // Reset state
        do_reset();
        check("pready", {31'b0, PREADY}, 32'h1);
        check("pslverr", {31'b0, PSLVERR}, 32'h0);
        fill_zero_tab();
        apply_tab("reset");

        // 150 high / 850 low, then a clearing read aligned with the next commit
        x_man = 1'b1; tick(150);
        x_man = 1'b0; tick(850);
        x_man = 1'b1; tick(3);
        tab.push_back('{32'h110, 32'h05});
        tab.push_back('{32'h108, 32'd1000});
        tab.push_back('{32'h104, 32'h0});
        tab.push_back('{32'h10C, 32'h0});
        tab.push_back('{32'h1FC, 32'h0});
        tab.push_back('{32'h100, 32'd150});
        tab.push_back('{32'h110, 32'h01});
        apply_tab("basic");
        tick(183);
        x_man = 1'b0; tick(800);
        x_man = 1'b1; tick(1);
        rd_chk("aligned pre-commit width", 32'h100, 32'd150);
        rd_chk("aligned new kept", 32'h110, 32'h05);
        rd_chk("second width", 32'h100, 32'd200);
        rd_chk("new cleared", 32'h110, 32'h01);
        rd_chk("second period", 32'h108, 32'd1000);

        // y loses signal, lost flag and W1C behaviour
        x_man = 1'b0;
        do_reset(); tick(5);
        y_man = 1'b1; tick(100);
        y_man = 1'b0; tick(400);
        y_man = 1'b1; tick(100);
        y_man = 1'b0;
        rd_chk("y width", 32'h104, 32'd100);
        rd_chk("y period", 32'h10C, 32'd500);
        tick(1097);
        rd_chk("y before timeout", 32'h110, 32'h02);
        rd_chk("y lost", 32'h110, 32'h20);
        rd_chk("y width lost", 32'h104, 32'h0);
        rd_chk("y period lost", 32'h10C, 32'h0);
        apb_write(32'h110, 32'h01);
        rd_chk("w1c wrong bit", 32'h110, 32'h20);
        apb_write(32'h110, 32'h20);
        rd_chk("w1c y lost", 32'h110, 32'h00);

        // Period TIMEOUT-1 commits; period TIMEOUT times out and needs a fresh cycle
        y_man = 1'b0;
        do_reset(); tick(5);
        x_man = 1'b1; tick(100);
        x_man = 1'b0; tick(TMO - 101);
        x_man = 1'b1; tick(3);
        rd_chk("period tmo-1", 32'h108, 32'(TMO - 1));
        rd_chk("width tmo-1", 32'h100, 32'd100);
        tick(93);
        x_man = 1'b0; tick(TMO - 100);
        x_man = 1'b1; tick(3);
        rd_chk("rise at timeout", 32'h110, 32'h10);
        rd_chk("period at timeout", 32'h108, 32'h0);
        rd_chk("width at timeout", 32'h100, 32'h0);
        tick(91);
        x_man = 1'b0; tick(400);
        x_man = 1'b1; tick(3);
        rd_chk("restart no commit", 32'h110, 32'h10);
        rd_chk("restart period", 32'h108, 32'h0);
        tick(93);
        x_man = 1'b0; tick(400);
        x_man = 1'b1; tick(3);
        rd_chk("restart status", 32'h110, 32'h15);
        rd_chk("restart period ok", 32'h108, 32'd500);
        rd_chk("restart width ok", 32'h100, 32'd100);

        // Input already high at reset release: partial pulse ignored
        x_man = 1'b1;
        do_reset(); tick(57);
        x_man = 1'b0; tick(940);
        x_man = 1'b1; tick(3);
        rd_chk("partial no commit", 32'h110, 32'h0);
        rd_chk("partial width", 32'h100, 32'h0);
        tick(113);
        x_man = 1'b0; tick(880);
        x_man = 1'b1; tick(3);
        rd_chk("partial status", 32'h110, 32'h05);
        rd_chk("partial period", 32'h108, 32'd1000);
        rd_chk("partial width ok", 32'h100, 32'd120);

        // Reset in the middle of a pulse
        x_man = 1'b0;
        do_reset(); tick(5);
        x_man = 1'b1; tick(150);
        x_man = 1'b0; tick(850);
        x_man = 1'b1; tick(3);
        rd_chk("pre-reset width", 32'h100, 32'd150);
        tick(70);
        PRESET = 1'b1; tick(1); PRESET = 1'b0;
        fill_zero_tab();
        apply_tab("midreset");
        tick(62);
        x_man = 1'b0; tick(850);
        x_man = 1'b1; tick(3);
        rd_chk("midreset no commit", 32'h110, 32'h0);
        tick(145);
        x_man = 1'b0; tick(850);
        x_man = 1'b1; tick(3);
        rd_chk("midreset width", 32'h100, 32'd150);
        rd_chk("midreset period", 32'h108, 32'd1000);

        // Both channels together, 100/500 and 300/700
        x_man = 1'b0;
        do_reset(); tick(5);
        x_hi = 100; x_lo = 500; y_hi = 300; y_lo = 700;
        x_en = 1'b1; tick(37);
        y_en = 1'b1; tick(1100);
        random_reads("dual", 20);

        // Randomized patterns
        for (int r = 0; r < 4; r++) begin
            x_en = 1'b0; y_en = 1'b0;
            do_reset(); tick(5);
            x_hi = $urandom_range(1, 500); x_lo = $urandom_range(1, 600);
            y_hi = $urandom_range(1, 500); y_lo = $urandom_range(1, 600);
            d  = $urandom_range(1, 50);
            px = x_hi + x_lo;
            py = y_hi + y_lo;
            w  = ((px > d + py) ? px : d + py) + 10 - d;
            x_en = 1'b1; tick(d);
            y_en = 1'b1; tick(w);
            random_reads($sformatf("rand%0d", r), 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
